// File: rtl/cache_arbiter_pkg.sv
// Shared types for the LC-3b memory-side cache arbiter: word/line widths,
// arbiter state encoding and the line-alignment helper.
package cache_arbiter_pkg;

    localparam int ADDR_W   = 16;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;

    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_c_line;

    // state          | meaning
    // arb_idle       | no owner, arbitrate on sampled requests
    // arb_serve_i    | I-cache owns the memory port until pmem_resp
    // arb_serve_d    | D-cache owns the memory port until pmem_resp
    // arb_done       | one dead cycle so the owner can drop its request
    typedef enum logic [1:0] {
        arb_idle,
        arb_serve_i,
        arb_serve_d,
        arb_done
    } lc3b_arb_state;

    function automatic lc3b_word line_align(input lc3b_word addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// and D-cache; the owner's request is steered out and the response steered back.
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,

    input  logic          i_pmem_read,
    input  lc3b_word      i_pmem_address,
    output lc3b_c_line    i_pmem_rdata,
    output logic          i_pmem_resp,

    input  logic          d_pmem_read,
    input  logic          d_pmem_write,
    input  lc3b_word      d_pmem_address,
    input  lc3b_c_line    d_pmem_wdata,
    output lc3b_c_line    d_pmem_rdata,
    output logic          d_pmem_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_c_line    pmem_wdata,
    input  lc3b_c_line    pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_state_next;
    logic          r_last_d;
    logic          r_d_is_write;
    logic          w_i_req;
    logic          w_d_req;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            arb_idle: begin
                if (w_i_req && w_d_req)
                    w_state_next = r_last_d ? arb_serve_i : arb_serve_d;
                else if (w_d_req)
                    w_state_next = arb_serve_d;
                else if (w_i_req)
                    w_state_next = arb_serve_i;
            end
            arb_serve_i,
            arb_serve_d: begin
                if (pmem_resp)
                    w_state_next = arb_done;
            end
            arb_done: w_state_next = arb_idle;
            default:  w_state_next = arb_idle;
        endcase
    end

    // The D operation is latched at grant so a dropped request still completes
    // with the strobe memory already saw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= arb_idle;
            r_last_d     <= 1'b0;
            r_d_is_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == arb_idle && w_state_next == arb_serve_d) begin
                r_last_d     <= 1'b1;
                r_d_is_write <= d_pmem_write;
            end else if (r_state == arb_idle && w_state_next == arb_serve_i) begin
                r_last_d     <= 1'b0;
            end
        end
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            arb_serve_i: begin
                pmem_read    = 1'b1;
                pmem_address = line_align(i_pmem_address);
                i_pmem_resp  = pmem_resp;
            end
            arb_serve_d: begin
                pmem_write   = r_d_is_write;
                pmem_read    = ~r_d_is_write;
                pmem_address = line_align(d_pmem_address);
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
